// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity mode constants.
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], i_rx};
    end

    assign o_rx = r_sync[1];
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with parity, framing, overrun and break handling.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx (+2 cycles latency).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 14,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int MSB_FIRST    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_3125,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);
    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1   = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0]  FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    logic                 w_rx;
    logic                 w_par_exp;
    uart_state_e          r_state;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit;
    logic                 r_stop;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_ferr, r_done;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_parity_err, r_frame_err, r_overrun;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk   (clk_3125),
        .rst_n (rst_n),
        .i_rx  (rx),
        .o_rx  (w_rx)
    );
`else
    assign w_rx = rx;
`endif

    assign w_par_exp = (^r_shift) ^ (PARITY_MODE == PARITY_ODD);

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_stop       <= 1'b0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_done       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            if (r_valid && rx_ready) r_valid <= 1'b0;

            // Result stage runs one edge after the final stop sample
            if (r_done) begin
                if (r_perr || r_ferr) begin
                    r_parity_err <= r_perr;
                    r_frame_err  <= r_ferr;
                end else if (r_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rx) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_stop  <= 1'b0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                        r_state <= w_rx ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (MSB_FIRST != 0) r_shift <= {r_shift[DATA_BITS-2:0], w_rx};
                        else                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_bit == LAST_BIT)
                            r_state <= (PARITY_MODE == PARITY_NONE) ? S_STOP : S_PARITY;
                        else
                            r_bit <= r_bit + 4'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_perr  <= (w_rx != w_par_exp);
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (!w_rx) r_ferr <= 1'b1;
                        if (r_stop == LAST_STOP) begin
                            r_done  <= 1'b1;
                            r_state <= w_rx ? S_IDLE : S_BREAK;
                        end else begin
                            r_stop <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rx) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_parity_err = r_parity_err;
    assign rx_frame_err  = r_frame_err;
    assign rx_overrun    = r_overrun;
    assign rx_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at default parameters: expected output events
// are queued when a frame is driven and matched as the DUT raises them.
module tb_uart_rx_cfg;
    localparam int CPB = 14;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int K_NONE = 0, K_VALID = 1, K_PERR = 2, K_FERR = 3, K_OVR = 4;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } exp_t;

    logic       clk_3125 = 1'b0;
    logic       rst_n, rx, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic       m_valid = 1'b0;
    logic       p_valid = 1'b0;
    logic [7:0] p_data  = '0;

    uart_rx_cfg dut (
        .clk_3125      (clk_3125),
        .rst_n         (rst_n),
        .rx            (rx),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_busy       (rx_busy)
    );

    always #5 clk_3125 = ~clk_3125;
    always @(posedge clk_3125) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic sb_pop(input int kind, input int data);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_evt", kind, K_NONE);
            return;
        end
        e = sb.pop_front();
        chk("evt_kind", kind, e.kind);
        chk("evt_data", data, e.data);
        chk("evt_cyc", cyc, e.cyc);
    endtask

    // Output monitor: a new load of rx_data or any flag cycle is one event.
    always @(negedge clk_3125) begin
        if (rst_n) begin
            if (rx_valid && (!p_valid || rx_data != p_data)) sb_pop(K_VALID, int'(rx_data));
            if (rx_parity_err) sb_pop(K_PERR, 0);
            if (rx_frame_err)  sb_pop(K_FERR, 0);
            if (rx_overrun)    sb_pop(K_OVR, 0);
        end
        p_valid = rx_valid;
        p_data  = rx_data;
    end

    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_v, input logic rdy_end);
        logic [10:0] bits;
        exp_t        e;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[7-i];
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_v;
        for (int b = 0; b < 11; b++) begin
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk_3125);
                rx = bits[b];
                if (b == 0 && k == 0) begin
                    e.cyc = cyc + 1 + 148 + LAT;
                    e.data = 0;
                    if (par_flip)                 e.kind = K_PERR;
                    else if (!stop_v)             e.kind = K_FERR;
                    else if (m_valid && !rdy_end) e.kind = K_OVR;
                    else begin
                        e.kind = K_VALID;
                        e.data = int'(d);
                        m_valid = 1'b1;
                    end
                    sb.push_back(e);
                end
                if (b == 0 && k == 1 + LAT) begin
                    #1 chk("busy_start", int'(rx_busy), 1);
                end
                if (b == 10 && k == 8 + LAT)  rx_ready = rdy_end;
                if (b == 10 && k == 9 + LAT)  rx_ready = 1'b0;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk_3125) rx_ready = 1'b1;
        @(negedge clk_3125) rx_ready = 1'b0;
        #1 chk("consume_valid", int'(rx_valid), 0);
        m_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_3125) rx = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge clk_3125);
        #1;
        chk("rst_data",  int'(rx_data), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_perr",  int'(rx_parity_err), 0);
        chk("rst_ferr",  int'(rx_frame_err), 0);
        chk("rst_ovr",   int'(rx_overrun), 0);
        chk("rst_busy",  int'(rx_busy), 0);
        @(negedge clk_3125) rst_n = 1'b1;
        idle(3);

        // Good frame, even parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        #1;
        chk("a5_valid", int'(rx_valid), 1);
        chk("a5_data",  int'(rx_data), 'hA5);
        consume();
        idle(4);

        // False start: low for 3 cycles only
        @(negedge clk_3125) rx = 1'b0;
        repeat (3) @(negedge clk_3125);
        rx = 1'b1;
        repeat (4 + LAT) @(negedge clk_3125);
        #1 chk("fs_busy_mid", int'(rx_busy), 1);
        repeat (2) @(negedge clk_3125);
        #1 chk("fs_busy_idle", int'(rx_busy), 0);
        idle(4);

        // Parity error leaves previous data in place
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        #1;
        chk("perr_valid", int'(rx_valid), 0);
        chk("perr_data",  int'(rx_data), 'hA5);
        idle(4);

        // Framing error followed by a held-low line (break)
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (30) @(negedge clk_3125) rx = 1'b0;
        #1 chk("brk_busy", int'(rx_busy), 1);
        chk("brk_data", int'(rx_data), 'hA5);
        idle(3 + LAT);
        #1 chk("brk_exit", int'(rx_busy), 0);
        idle(20);
        chk("brk_no_start", int'(rx_busy), 0);

        // Back-to-back: load, overrun, then replace with ready on completion
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        #1 chk("ovr_keep", int'(rx_data), 'h3C);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        #1;
        chk("rdy_data",  int'(rx_data), 'hC3);
        chk("rdy_valid", int'(rx_valid), 1);
        idle(4);

        // Reset mid-frame with a valid word pending
        @(negedge clk_3125) rx = 1'b0;
        for (int k = 0; k < 60; k++) @(negedge clk_3125) rx = (k >= 14) ? k[3] : 1'b0;
        #1 chk("pre_rst_busy", int'(rx_busy), 1);
        rst_n = 1'b0; rx = 1'b1;
        #1;
        chk("mid_rst_data",  int'(rx_data), 0);
        chk("mid_rst_valid", int'(rx_valid), 0);
        chk("mid_rst_busy",  int'(rx_busy), 0);
        chk("mid_rst_flags", int'({rx_parity_err, rx_frame_err, rx_overrun}), 0);
        m_valid = 1'b0;
        repeat (2) @(negedge clk_3125);
        rst_n = 1'b1;
        idle(3);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        #1 chk("post_rst_data", int'(rx_data), 'h81);
        idle(10);

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 14, clock cycles per bit period (minimum 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY_MODE, default 1, where 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter MSB_FIRST, default 1, where 1 = first data bit received lands in rx_data[DATA_BITS-1] and 0 = first bit lands in rx_data[0].
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-006 SHALL have ports as follows; one clock; reset is asynchronous and active-low:
- clk_3125  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, idle high.
- rx_ready  in  1  consumer accepts rx_data.
- rx_data  out  DATA_BITS  received word.
- rx_valid  out  1  rx_data holds an unconsumed good frame.
- rx_parity_err  out  1  one-cycle pulse on parity mismatch.
- rx_frame_err  out  1  one-cycle pulse on a low stop bit.
- rx_overrun  out  1  one-cycle pulse when a good frame is dropped.
- rx_busy  out  1  high in every state except IDLE.

Function
REQ-007 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-008 SHALL move IDLE->START on the first edge where rx is sampled 0; call this edge cycle 0.
REQ-009 SHALL resample rx in START at cycle CLKS_PER_BIT/2 (integer division), going to DATA if 0 and to IDLE (false start, no flags) if 1.
REQ-010 SHALL take each later sample exactly CLKS_PER_BIT cycles after the previous one, using a baud counter of width $clog2(CLKS_PER_BIT) that is cleared on every sample.
REQ-011 SHALL capture DATA_BITS samples in DATA, placed according to MSB_FIRST.
REQ-012 SHALL go from DATA to STOP when PARITY_MODE=0 and to PARITY otherwise.
REQ-013 SHALL compute expected parity as the XOR of the data bits (even mode) or its inverse (odd mode), and flag a mismatch against the received parity bit.
REQ-014 SHALL check STOP_BITS stop samples, any of which being 0 is a framing error.
REQ-015 SHALL, on the final stop sample, go to IDLE when the stop sample is 1 and to BREAK when it is 0.
REQ-016 SHALL stay in BREAK until rx is sampled 1, then go to IDLE.
REQ-017 SHALL, for a good frame (no parity or framing error), load rx_data and set rx_valid on the edge after the final stop sample.
REQ-018 SHALL, for a bad frame, pulse the applicable error flag(s) for one cycle on that same edge, leaving rx_data and rx_valid unchanged.
REQ-019 SHALL clear rx_valid on any edge where rx_valid=1 and rx_ready=1.
REQ-020 SHALL, when a good frame completes while rx_valid=1 and rx_ready=0, keep the old rx_data, drop the new frame and pulse rx_overrun.
REQ-021 SHALL, when a good frame completes while rx_valid=1 and rx_ready=1, load the new data, keep rx_valid=1 and leave rx_overrun at 0.
REQ-022 SHALL treat an unreachable state encoding as IDLE on the next edge.

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, rx_data=0, rx_valid=0, all error flags 0, rx_busy=0 and the counters to 0.
REQ-024 SHALL abort any in-progress frame on reset with no rx_valid and no flags, and resume start detection on the first edge after rst_n rises.

Configuration
REQ-025 SHALL, with UART_RX_SYNC_EN defined, pass rx through a 2-flop synchronizer reset to 1, so every timing value in REQ-008..REQ-017 is measured from the synchronized signal and adds 2 cycles relative to the pin.
REQ-026 SHALL, without UART_RX_SYNC_EN, sample rx directly with no extra latency.

Structure
REQ-027 SHALL take the state enum and the PARITY_NONE/EVEN/ODD constants from shared package uart_pkg.
REQ-028 SHALL place the synchronizer in sub-module uart_rx_sync, instantiated only under UART_RX_SYNC_EN.

Verification (defaults, macro off, cycle 0 per REQ-008)
REQ-029 SHALL cover 0xA5 with parity 0 and stop 1 -> start sample at cycle 7, stop sample at cycle 147, rx_valid=1 and rx_data=0xA5 from cycle 148, no flags.
REQ-030 SHALL cover rx low for 3 cycles then high -> back in IDLE at cycle 8, no rx_valid, no flags.
REQ-031 SHALL cover 0xA5 with parity 1 -> rx_parity_err pulses for one cycle at cycle 148, no rx_valid.
REQ-032 SHALL cover 0x3C with stop bit 0, then rx held low for 30 cycles -> rx_frame_err pulses at 148, FSM stays in BREAK until rx returns high, no false start detected.
REQ-033 SHALL cover back-to-back 0x3C then 0xC3 with rx_ready=0 -> rx_data stays 0x3C and rx_overrun pulses once; with rx_ready=1 on the second completion edge, rx_data=0xC3.
REQ-034 SHALL cover rst_n pulsed low at cycle 60 of a frame -> all outputs 0 immediately, and the next full frame 0x81 is received correctly.
